// File: rtl/trap_ram_if.sv
// Data-port bus of the tenyr core as seen by trap_ram: cycle strobe, direction and word address.
// The bidirectional data lines stay a plain inout port on the responder.
interface trap_ram_if;
  logic        strobe;
  logic        mem_rw;
  logic [31:0] d_addr;

  modport master (output strobe, mem_rw, d_addr);
  modport slave  (input  strobe, mem_rw, d_addr);
endinterface

// File: rtl/trap_ram.sv
// trap_ram: word RAM plus a 4-word trap register window (EPC, RELOAD, COUNT, CAUSE) on the tenyr data bus.
// Drives `trap` from an external irq and, when TRAP_TIMER_EN is defined, from a countdown timer.
`ifndef TRAP_ADDR
`define TRAP_ADDR 32'h0001_0000
`endif

module trap_ram #(
  parameter logic [31:0] BASE       = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] TRAP_ADDR  = `TRAP_ADDR
) (
  input  logic             clk,
  input  logic             reset_n,
  trap_ram_if.slave        bus,
  inout  wire  [31:0]      d_data,
  input  logic             irq,
  output logic             trap
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [1:0] REG_EPC    = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_CAUSE  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_SERVICE} state_e;

  logic [32:0] w_off;
  logic        w_win_hit, w_ram_hit;
  logic        w_rd, w_wr;
  logic        w_epc_wr, w_cause_wr;
  logic [31:0] w_rdata;
  logic [31:0] w_reload_q, w_count_q;
  logic        w_timer_ev, w_ext_ev;

  logic [31:0] r_mem [DEPTH];
  logic [2:0]  r_sync;
  state_e      r_state, w_state_next;
  logic        r_trap, w_trap_next;
  logic        w_ack, w_eos;
  logic [1:0]  r_pending, w_pending_next, w_taken;
  logic [1:0]  r_cause;
  logic [31:0] r_epc;

  // 33-bit offset keeps the range test free of wraparound at the top of the address space.
  assign w_off     = {1'b0, bus.d_addr} - {1'b0, BASE};
  assign w_win_hit = (bus.d_addr[31:2] == TRAP_ADDR[31:2]);
  assign w_ram_hit = ~w_win_hit && (w_off[32:DEPTH_LOG2] == '0);

  assign w_rd       = reset_n & bus.strobe & ~bus.mem_rw & (w_win_hit | w_ram_hit);
  assign w_wr       = bus.strobe & bus.mem_rw;
  assign w_epc_wr   = w_wr & w_win_hit & (bus.d_addr[1:0] == REG_EPC);
  assign w_cause_wr = w_wr & w_win_hit & (bus.d_addr[1:0] == REG_CAUSE);

  // NOTE: the RAM array has no reset branch; clearing it would force flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (w_wr && w_ram_hit)
      r_mem[w_off[DEPTH_LOG2-1:0]] <= d_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[1:0], irq};
  end
  assign w_ext_ev = r_sync[1] & ~r_sync[2];

`ifdef TRAP_TIMER_EN
  logic        w_reload_wr;
  logic [31:0] r_reload, r_count;

  assign w_reload_wr = w_wr & w_win_hit & (bus.d_addr[1:0] == REG_RELOAD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reload <= '0;
      r_count  <= '0;
    end else if (w_reload_wr) begin
      r_reload <= d_data;
      r_count  <= d_data;
    end else if (r_reload != '0) begin
      if (r_count != '0) r_count <= r_count - 32'd1;
      else               r_count <= r_reload;
    end
  end

  // A RELOAD write on the expiry cycle suppresses that expiry.
  assign w_timer_ev = ~w_reload_wr & (r_reload != '0) & (r_count == '0);
  assign w_reload_q = r_reload;
  assign w_count_q  = r_count;
`else
  assign w_timer_ev = 1'b0;
  assign w_reload_q = '0;
  assign w_count_q  = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_trap  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_trap  <= w_trap_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_ack        = 1'b0;
    w_eos        = 1'b0;
    case (r_state)
      S_IDLE:    if (r_pending != 2'b00) w_state_next = S_PEND;
      S_PEND:    if (w_epc_wr) begin
                   w_ack        = 1'b1;
                   w_state_next = S_SERVICE;
                 end
      S_SERVICE: if (w_cause_wr) begin
                   w_eos        = 1'b1;
                   w_state_next = S_IDLE;
                 end
      default:   w_state_next = S_IDLE;
    endcase
    w_trap_next = (w_state_next == S_PEND);
  end

  assign w_taken        = w_ack ? r_pending : 2'b00;
  assign w_pending_next = (r_pending & ~w_taken) | {w_ext_ev, w_timer_ev};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_cause   <= '0;
      r_epc     <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (w_epc_wr) r_epc   <= d_data;
      if (w_ack)    r_cause <= r_pending;
      else if (w_eos) r_cause <= '0;
    end
  end

  always_comb begin
    w_rdata = r_mem[w_off[DEPTH_LOG2-1:0]];
    if (w_win_hit) begin
      case (bus.d_addr[1:0])
        REG_EPC:    w_rdata = r_epc;
        REG_RELOAD: w_rdata = w_reload_q;
        REG_COUNT:  w_rdata = w_count_q;
        default:    w_rdata = {30'd0, r_cause};
      endcase
    end
  end

  assign d_data = w_rd ? w_rdata : 'z;
  assign trap   = r_trap;
endmodule

// File: tb/tb_trap_ram.sv
// Directed bench for trap_ram: RAM decode, register window, irq trap, ack-cycle events and reset.
// The data bus is pulled up, so a non-responding DUT reads as all ones.
module tb_trap_ram;
  localparam logic [31:0] BASE    = 32'h0000_2000;
  localparam int          DL2     = 4;
  localparam logic [31:0] TA      = 32'h0001_0000;
  localparam logic [31:0] A_EPC   = TA;
  localparam logic [31:0] A_RLD   = TA + 32'd1;
  localparam logic [31:0] A_CNT   = TA + 32'd2;
  localparam logic [31:0] A_CAUSE = TA + 32'd3;
  localparam logic [31:0] IDLE_BUS = 32'hFFFF_FFFF;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic        irq     = 1'b0;
  logic        trap;
  logic        r_drv   = 1'b0;
  logic [31:0] r_wdata = '0;
  logic [31:0] r_rd;
  tri1  [31:0] d_data;
  int          tests = 0;
  int          fails = 0;

  trap_ram_if bus_if ();

  assign d_data = r_drv ? r_wdata : 'z;

  trap_ram #(.BASE(BASE), .DEPTH_LOG2(DL2), .TRAP_ADDR(TA)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .d_data  (d_data),
    .irq     (irq),
    .trap    (trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_trap(input string tag, input logic exp);
    check(tag, {31'd0, trap}, {31'd0, exp});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_if.strobe = 1'b1;
    bus_if.mem_rw = 1'b1;
    bus_if.d_addr = addr;
    r_wdata       = data;
    r_drv         = 1'b1;
    @(posedge clk);
    #1;
    bus_if.strobe = 1'b0;
    bus_if.mem_rw = 1'b0;
    r_drv         = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus_if.strobe = 1'b1;
    bus_if.mem_rw = 1'b0;
    bus_if.d_addr = addr;
    @(negedge clk);
    data = d_data;
    @(posedge clk);
    #1;
    bus_if.strobe = 1'b0;
  endtask

  initial begin
    bus_if.strobe = 1'b0;
    bus_if.mem_rw = 1'b0;
    bus_if.d_addr = '0;

    #1 reset_n = 1'b0;
    #1 check_trap("rst_trap", 1'b0);
    bus_if.strobe = 1'b1;
    bus_if.d_addr = BASE + 32'd5;
    #1 check("rst_bus_idle", d_data, IDLE_BUS);
    bus_if.strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cycles(1);

    // RAM window and its edges
    bus_write(BASE + 32'd5, 32'hDEAD_BEEF);
    bus_read(BASE + 32'd5, r_rd);   check("ram_rd5", r_rd, 32'hDEAD_BEEF);
    bus_write(BASE + 32'd15, 32'h1234_5678);
    bus_read(BASE + 32'd15, r_rd);  check("ram_rd_last", r_rd, 32'h1234_5678);
    bus_read(BASE + 32'd16, r_rd);  check("ram_above", r_rd, IDLE_BUS);
    bus_read(BASE - 32'd1, r_rd);   check("ram_below", r_rd, IDLE_BUS);
    bus_read(A_EPC, r_rd);          check("epc_init", r_rd, 32'd0);
    bus_read(A_CAUSE, r_rd);        check("cause_init", r_rd, 32'd0);

`ifdef TRAP_TIMER_EN
    bus_write(A_RLD, 32'd3);
    cycles(4);                      check_trap("tmr_early", 1'b0);
    cycles(1);                      check_trap("tmr_rise", 1'b1);
    bus_write(A_EPC, 32'h100);      check_trap("tmr_ack_fall", 1'b0);
    bus_read(A_EPC, r_rd);          check("tmr_epc", r_rd, 32'h100);
    bus_read(A_CAUSE, r_rd);        check("tmr_cause", r_rd, 32'd1);
    cycles(6);                      check_trap("tmr_masked", 1'b0);
    bus_write(A_CAUSE, 32'd0);      check_trap("tmr_eos_gap", 1'b0);
    cycles(1);                      check_trap("tmr_retrap", 1'b1);
    bus_write(A_RLD, 32'd0);
    bus_write(A_EPC, 32'h200);      check_trap("tmr_ack2_fall", 1'b0);
    bus_read(A_CAUSE, r_rd);        check("tmr_cause2", r_rd, 32'd1);
    bus_read(A_CNT, r_rd);          check("tmr_count_stop", r_rd, 32'd0);
    bus_write(A_CAUSE, 32'd0);
    cycles(3);                      check_trap("tmr_quiet", 1'b0);
`else
    bus_write(A_RLD, 32'd5);
    bus_read(A_RLD, r_rd);          check("reload_absent", r_rd, 32'd0);
    bus_read(A_CNT, r_rd);          check("count_absent", r_rd, 32'd0);
    cycles(8);                      check_trap("no_timer_trap", 1'b0);
`endif

    // External request: 2-cycle irq pulse
    irq = 1'b1;
    cycles(2);
    irq = 1'b0;
    cycles(1);                      check_trap("ext_early", 1'b0);
    cycles(1);                      check_trap("ext_rise", 1'b1);
    bus_write(A_EPC, 32'h300);      check_trap("ext_fall", 1'b0);
    bus_read(A_CAUSE, r_rd);        check("ext_cause", r_rd, 32'd2);
    bus_read(A_EPC, r_rd);          check("ext_epc", r_rd, 32'h300);
    bus_write(A_CAUSE, 32'd0);
    cycles(4);                      check_trap("ext_quiet", 1'b0);

    // EPC write while idle only updates EPC
    bus_write(A_EPC, 32'h55);
    bus_read(A_EPC, r_rd);          check("epc_idle", r_rd, 32'h55);
    cycles(2);                      check_trap("epc_idle_notrap", 1'b0);

    // Second irq edge lands on the ack cycle and must stay pending
    irq = 1'b1;
    cycles(1);
    irq = 1'b0;
    cycles(2);
    irq = 1'b1;
    cycles(1);                      check_trap("ack_rise", 1'b1);
    cycles(1);
    bus_write(A_EPC, 32'h400);      check_trap("ack_fall", 1'b0);
    bus_read(A_CAUSE, r_rd);        check("ack_cause", r_rd, 32'd2);
    cycles(2);                      check_trap("ack_masked", 1'b0);
    bus_write(A_CAUSE, 32'd0);      check_trap("ack_eos_gap", 1'b0);
    cycles(1);                      check_trap("ack_retrap", 1'b1);
    bus_write(A_EPC, 32'h500);      check_trap("ack2_fall", 1'b0);
    bus_read(A_CAUSE, r_rd);        check("ack_cause2", r_rd, 32'd2);
    bus_write(A_CAUSE, 32'd0);

    // Reset while trap is high
    irq = 1'b0;
    cycles(3);
    irq = 1'b1;
    cycles(4);                      check_trap("pre_rst_trap", 1'b1);
    #2 reset_n = 1'b0;
    #1 check_trap("rst_async", 1'b0);
    bus_if.strobe = 1'b1;
    bus_if.mem_rw = 1'b0;
    bus_if.d_addr = A_CAUSE;
    #1 check("rst_bus_quiet", d_data, IDLE_BUS);
    bus_if.strobe = 1'b0;
    irq = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cycles(1);
    bus_read(A_CAUSE, r_rd);        check("rst_cause", r_rd, 32'd0);
    bus_read(A_CNT, r_rd);          check("rst_count", r_rd, 32'd0);
    bus_read(A_EPC, r_rd);          check("rst_epc", r_rd, 32'd0);
    bus_read(BASE + 32'd5, r_rd);   check("ram_kept", r_rd, 32'hDEAD_BEEF);
    cycles(6);                      check_trap("rst_no_trap", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
